// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte/half store merge and load extension, LED snoop, writable cycle timer, misalign flag.
// Latency: loads are combinational (zero cycle); stores, LED, timer and flag update on the rising clk edge.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   MemWriteM    store strobe for the current access (otherwise the access is a load)
//   ALUResultM   byte address
//   WriteDataM   right-aligned store data
//   DextControlM funct3 access size / extension code
//   ReadDataM    extended load data (combinational)
//   ledON        LED register
//   misalignErr  sticky misaligned-access flag
module data_mem_responder #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter logic [31:0] LED_ADDR   = 32'd100,
  parameter logic [31:0] LED_MATCH  = 32'd25,
  parameter logic [31:0] TIMER_ADDR = 32'h0000_0FF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  DextControlM,
  output logic [31:0] ReadDataM,
  output logic        ledON,
  output logic        misalignErr
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] timer_q, timer_d;
  logic        led_q, led_d;
  logic        mis_q, mis_d;

  logic          in_ram, in_timer;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word, rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Access classification. Loads and stores decode funct3 differently:
  // 100/101 are unsigned byte/half loads, but stores treat them as words.
  logic ld_byte_acc, ld_half_acc, ld_word_acc;
  logic st_byte_acc, st_half_acc, st_word_acc;
  logic ld_misalign, st_misalign, misalign_evt;
  logic ram_we;
  logic [3:0]  wr_mask;
  logic [31:0] wr_lanes, merged_word;

  assign in_ram   = (ALUResultM < RAM_BYTES);
  assign in_timer = (ALUResultM[31:2] == TIMER_ADDR[31:2]);
  assign word_idx = ALUResultM[AW+1:2];
  assign ram_word = mem_q[word_idx];

  // Unmapped addresses read as zero, so every extension of them is zero too.
  assign rd_word = in_ram   ? ram_word :
                   in_timer ? timer_q  : 32'd0;

  assign ld_byte_acc = (DextControlM == 3'b000) || (DextControlM == 3'b100);
  assign ld_half_acc = (DextControlM == 3'b001) || (DextControlM == 3'b101);
  assign ld_word_acc = !ld_byte_acc && !ld_half_acc;
  assign st_byte_acc = (DextControlM == 3'b000);
  assign st_half_acc = (DextControlM == 3'b001);
  assign st_word_acc = !st_byte_acc && !st_half_acc;

  assign ld_misalign = (ld_half_acc && ALUResultM[0]) || (ld_word_acc && (ALUResultM[1:0] != 2'b00));
  assign st_misalign = (st_half_acc && ALUResultM[0]) || (st_word_acc && (ALUResultM[1:0] != 2'b00));

  // Unmapped stores are silent even when misaligned; loads always count.
  assign misalign_evt = MemWriteM ? (st_misalign && (in_ram || in_timer)) : ld_misalign;

  // Gating with reset drops a store that coincides with an asserted reset.
  assign ram_we = reset && MemWriteM && in_ram && !st_misalign;

  // Load extension
  always_comb begin
    ld_byte   = rd_word[{ALUResultM[1:0], 3'b000} +: 8];
    ld_half   = ALUResultM[1] ? rd_word[31:16] : rd_word[15:0];
    ReadDataM = rd_word;
    case (DextControlM)
      3'b000:  ReadDataM = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ReadDataM = {24'd0, ld_byte};
      3'b001:  ReadDataM = {{16{ld_half[15]}}, ld_half};
      3'b101:  ReadDataM = {16'd0, ld_half};
      default: ReadDataM = rd_word;
    endcase
  end

  // Store lane merge: replicate the data across lanes, then pick per lane.
  always_comb begin
    wr_mask     = 4'b1111;
    wr_lanes    = WriteDataM;
    merged_word = ram_word;
    if (st_byte_acc) begin
      wr_mask  = 4'b0001 << ALUResultM[1:0];
      wr_lanes = {4{WriteDataM[7:0]}};
    end else if (st_half_acc) begin
      wr_mask  = ALUResultM[1] ? 4'b1100 : 4'b0011;
      wr_lanes = {2{WriteDataM[15:0]}};
    end
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = wr_mask[i] ? wr_lanes[8*i +: 8] : ram_word[8*i +: 8];
    end
  end

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (MemWriteM && in_timer && st_word_acc && (ALUResultM[1:0] == 2'b00)) begin
      timer_d = WriteDataM;
    end
    led_d = led_q;
    if (ram_we && st_word_acc && (ALUResultM == LED_ADDR)) begin
      led_d = (WriteDataM == LED_MATCH);
    end
    mis_d = mis_q || misalign_evt;
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= 32'd0;
      led_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      led_q   <= led_d;
      mis_q   <= mis_d;
    end
  end

  assign ledON       = led_q;
  assign misalignErr = mis_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the five-stage RISC-V pipeline: serves the core's Memory-stage data port (MemWriteM, ALUResultM, WriteDataM, DextControlM) and returns ReadDataM. It contains word-organised RAM with byte/halfword store merging and load extension, a sticky LED register, a writable free-running cycle timer and a sticky misalignment flag. It sits beside the core in the top level, on the data side only; instruction fetch is served elsewhere.

## Interface
- MEM_WORDS, 256, RAM depth in 32-bit words; byte addresses 0 .. 4*MEM_WORDS-1 map to RAM.
- LED_ADDR, 32'd100, word address of the LED snoop register; must be word-aligned.
- LED_MATCH, 32'd25, word value that switches the LED on.
- TIMER_ADDR, 32'h0000_0FF0, word address of the cycle timer; must lie outside RAM.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store strobe for the current M-stage access.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- DextControlM  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ReadDataM  out  32  extended load data, combinational.
- ledON  out  1  LED register.
- misalignErr  out  1  sticky misaligned-access flag.

## Operation
- Region decode on ALUResultM: RAM (addr < 4*MEM_WORDS), TIMER (addr[31:2] == TIMER_ADDR[31:2]), otherwise unmapped.
- Loads are always active (no read strobe): ReadDataM is computed every cycle from the addressed word.
  - 000: byte at addr[1:0], sign-extended. 100: the same byte, zero-extended.
  - 001: half at addr[1], sign-extended. 101: the same half, zero-extended. 010: whole word.
  - Codes 011, 110 and 111 return the whole word.
  - Unmapped addresses return 0. TIMER returns the timer's current (pre-edge) value, extended like RAM.
- Stores occur on the clk edge when MemWriteM=1.
  - 000 writes byte lane addr[1:0] from WriteDataM[7:0].
  - 001 writes the half lane from WriteDataM[15:0].
  - 010 writes the full word. Other codes are treated as 010.
  - Unaddressed lanes are preserved by a read-modify-write merge within the single cycle.
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - A misaligned store is dropped.
  - Any misaligned load or store sets misalignErr, which stays set until reset.
  - A misaligned load still returns data from the word containing the address.
- Unmapped stores are dropped silently and do not set any flag.
- LED: a word store (010) to LED_ADDR also writes RAM.
  - ledON becomes 1 if WriteDataM==LED_MATCH, otherwise 0.
  - Byte or half stores to LED_ADDR update RAM only; ledON is unchanged.
- Timer: 32-bit counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0.
  - An aligned word store to TIMER_ADDR loads WriteDataM, and this replaces the increment for that edge.
  - A byte or half store to TIMER_ADDR is dropped.

## Timing
- Reset (reset=0, asynchronous):
  - ledON=0, misalignErr=0, timer=0.
  - A store in progress during reset is dropped.
  - RAM contents are not reset and are undefined until written.
- ReadDataM has zero-cycle latency, combinational from ALUResultM, DextControlM, RAM and timer state.
- Store-to-load: a load in the cycle after a store to the same word sees the merged data. A load in the same cycle as a store sees the pre-store data, since the core never issues both at once.
- ledON and misalignErr update on the edge that completes the triggering access and are visible in the following cycle.
- Timer read at cycle N returns N counts since reset. After a timer write of V at edge E, a read in the next cycle returns V, and V+k k cycles later.
- Reset released mid-program: the first edge after deassertion performs normal stores and a timer increment to 1.

## Test plan
- Load extension: sw 0x8000_00F1 @0x10, then read back @0x10 -> lb 0xFFFF_FFF1, lbu 0x0000_00F1, lh @0x12 0xFFFF_8000, lhu @0x12 0x0000_8000.
- Byte/half merge: after the above, sb 0xAB @0x11 then sh 0x1234 @0x12 -> lw @0x10 = 0x1234_ABF1.
- LED: sw 25 @100 -> ledON=1 next cycle and lw @100 = 25; sb 26 @100 -> ledON stays 1; sw 26 @100 -> ledON=0.
- Misalignment: sw 0xDEAD_BEEF @0x22 -> lw @0x20 unchanged and misalignErr=1; a following aligned sw succeeds and misalignErr stays 1 until reset.
- Timer: read TIMER_ADDR at cycle 10 after reset -> 10; sw 0xFFFF_FFFE @TIMER_ADDR -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0 on consecutive cycles (wrap).
- Reset mid-operation: drive reset=0 while sw 25 @100 is presented -> ledON=0, timer=0 and misalignErr=0; unmapped sw @0x2000 -> no flag, lw @0x2000 = 0.
